// File: rtl/vcache_stat_dumper.sv
// Vcache statistics dumper: counts load/store hits and misses on accepted responses and,
// on request, streams a six-beat snapshot (tag, global cycle, four counters) downstream.
module vcache_stat_dumper #(
  parameter int data_width_p    = 32,
  parameter int ctr_width_p     = 32,
  parameter bit clear_on_dump_p = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cache_v_o_i,
  input  logic                    cache_yumi_i,
  input  logic                    miss_v_i,
  input  logic                    ld_op_i,
  input  logic                    st_op_i,
  input  logic [31:0]             global_ctr_i,
  input  logic                    print_stat_v_i,
  input  logic [data_width_p-1:0] print_stat_tag_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state, state_next;
  logic [2:0]              beat, beat_next;
  logic                    resp;
  logic                    accept;
  logic [3:0]              ev;
  logic [ctr_width_p-1:0]  cnt      [4];
  logic [ctr_width_p-1:0]  cnt_snap [4];
  logic [data_width_p-1:0] tag_snap;
  logic [31:0]             gctr_snap;

  // Event order in ev/cnt: 0 load, 1 store, 2 load miss, 3 store miss.
  assign resp   = cache_v_o_i & cache_yumi_i;
  assign ev     = {resp & st_op_i & miss_v_i, resp & ld_op_i & miss_v_i,
                   resp & st_op_i, resp & ld_op_i};
  assign accept = print_stat_v_i & ready_o;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (reset_i)
        cnt[i] <= '0;
      else if (clear_on_dump_p && accept)
        cnt[i] <= ctr_width_p'(ev[i]);
      else
        cnt[i] <= cnt[i] + ctr_width_p'(ev[i]);
    end
  end

  // Snapshot takes the pre-update counters, so a same-cycle event lands only in the live count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_snap  <= '0;
      gctr_snap <= '0;
      for (int i = 0; i < 4; i++) cnt_snap[i] <= '0;
    end else if (accept) begin
      tag_snap  <= print_stat_tag_i;
      gctr_snap <= global_ctr_i;
      for (int i = 0; i < 4; i++) cnt_snap[i] <= cnt[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      beat  <= 3'd0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          beat_next  = 3'd0;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (beat == 3'd5) begin
            state_next = IDLE;
            beat_next  = 3'd0;
          end else begin
            beat_next = beat + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = 3'd0;
      end
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE) & ~reset_i;
    v_o     = (state == SEND) & ~reset_i;
    data_o  = '0;
    if (v_o) begin
      case (beat)
        3'd0:    data_o = tag_snap;
        3'd1:    data_o = data_width_p'(gctr_snap);
        3'd2:    data_o = data_width_p'(cnt_snap[0]);
        3'd3:    data_o = data_width_p'(cnt_snap[1]);
        3'd4:    data_o = data_width_p'(cnt_snap[2]);
        3'd5:    data_o = data_width_p'(cnt_snap[3]);
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vcache_stat_dumper.sv
// Bench for vcache_stat_dumper: three instances (plain, clear-on-dump, 4-bit counters) share
// stimulus; a per-instance scoreboard queue holds the beats each acceptance should produce.
module tb_vcache_stat_dumper;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic cv = 1'b0, cy = 1'b0, miss = 1'b0, ld = 1'b0, st = 1'b0, pv = 1'b0, yumi = 1'b0;
  logic [31:0]   gctr = 32'hC000_0100;
  logic [DW-1:0] tag  = '0;
  logic          rdy [3];
  logic          vo  [3];
  logic [DW-1:0] dat [3];

  always @(posedge clk) gctr <= gctr + 32'd1;

  vcache_stat_dumper #(.data_width_p(DW), .ctr_width_p(32), .clear_on_dump_p(1'b0)) u_plain (
    .clk_i(clk), .reset_i(reset), .cache_v_o_i(cv), .cache_yumi_i(cy), .miss_v_i(miss),
    .ld_op_i(ld), .st_op_i(st), .global_ctr_i(gctr), .print_stat_v_i(pv),
    .print_stat_tag_i(tag), .ready_o(rdy[0]), .v_o(vo[0]), .data_o(dat[0]), .yumi_i(yumi));

  vcache_stat_dumper #(.data_width_p(DW), .ctr_width_p(32), .clear_on_dump_p(1'b1)) u_clear (
    .clk_i(clk), .reset_i(reset), .cache_v_o_i(cv), .cache_yumi_i(cy), .miss_v_i(miss),
    .ld_op_i(ld), .st_op_i(st), .global_ctr_i(gctr), .print_stat_v_i(pv),
    .print_stat_tag_i(tag), .ready_o(rdy[1]), .v_o(vo[1]), .data_o(dat[1]), .yumi_i(yumi));

  vcache_stat_dumper #(.data_width_p(DW), .ctr_width_p(4), .clear_on_dump_p(1'b0)) u_narrow (
    .clk_i(clk), .reset_i(reset), .cache_v_o_i(cv), .cache_yumi_i(cy), .miss_v_i(miss),
    .ld_op_i(ld), .st_op_i(st), .global_ctr_i(gctr), .print_stat_v_i(pv),
    .print_stat_tag_i(tag), .ready_o(rdy[2]), .v_o(vo[2]), .data_o(dat[2]), .yumi_i(yumi));

  logic [31:0] sbq [3][$];
  logic [31:0] got [3][$];
  logic [31:0] cnt [3][4];
  int          n_chk = 0, n_fail = 0, cyc = 0, vcount = 0;
  int          acc_cyc[$];
  int          end_cyc[$];
  logic [31:0] acc_g = '0;

  task automatic check(input string nm, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h expected %h", nm, k, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle, advance the model for this cycle's inputs, then cross the edge.
  task automatic tick();
    logic        resp;
    logic [3:0]  ev;
    logic        acc;
    logic [31:0] m;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("ready_o", k, 32'(rdy[k]), 32'(!reset && sbq[k].size() == 0));
      check("v_o", k, 32'(vo[k]), 32'(!reset && sbq[k].size() != 0));
      if (!reset && sbq[k].size() != 0) check("beat", k, dat[k], sbq[k][0]);
      else check("idle_data", k, dat[k], 32'd0);
    end
    resp = cv & cy;
    ev   = {resp & st & miss, resp & ld & miss, resp & st, resp & ld};
    acc  = pv & !reset & (sbq[0].size() == 0);
    if (acc) begin
      acc_cyc.push_back(cyc);
      acc_g = gctr;
    end
    if (!reset && yumi && sbq[0].size() == 1) end_cyc.push_back(cyc);
    if (vo[0]) vcount++;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        sbq[k].delete();
        for (int j = 0; j < 4; j++) cnt[k][j] = 32'd0;
      end else begin
        if (sbq[k].size() != 0 && yumi) begin
          got[k].push_back(dat[k]);
          void'(sbq[k].pop_front());
        end
        if (acc) begin
          sbq[k].push_back(tag);
          sbq[k].push_back(gctr);
          for (int j = 0; j < 4; j++) sbq[k].push_back(cnt[k][j]);
        end
        m = (k == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
        for (int j = 0; j < 4; j++)
          cnt[k][j] = (k == 1 && acc) ? 32'(ev[j]) : ((cnt[k][j] + 32'(ev[j])) & m);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic events(input int n, input logic l, input logic s, input logic ms);
    for (int i = 0; i < n; i++) begin
      cv = 1'b1; cy = 1'b1; ld = l; st = s; miss = ms;
      tick();
    end
    cv = 1'b0; cy = 1'b0; ld = 1'b0; st = 1'b0; miss = 1'b0;
  endtask

  task automatic dump(input logic [31:0] t, input int hold_beat, input int hold_n, input logic ld_evt);
    int held;
    held = 0;
    for (int k = 0; k < 3; k++) got[k].delete();
    pv = 1'b1; tag = t; cv = ld_evt; cy = ld_evt; ld = ld_evt; yumi = 1'b0;
    tick();
    pv = 1'b0; cv = 1'b0; cy = 1'b0; ld = 1'b0;
    for (int i = 0; i < 60 && sbq[0].size() != 0; i++) begin
      yumi = 1'b1;
      if (got[0].size() == hold_beat && held < hold_n) begin
        yumi = 1'b0;
        held++;
      end
      tick();
    end
    yumi = 1'b0;
    check("dump_done", 0, 32'(sbq[0].size()), 32'd0);
  endtask

  task automatic expect_beats(input int k, input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3,
                              input logic [31:0] b4, input logic [31:0] b5);
    logic [31:0] e [6];
    e = '{b0, b1, b2, b3, b4, b5};
    check("beat_count", k, 32'(got[k].size()), 32'd6);
    if (got[k].size() == 6)
      for (int i = 0; i < 6; i++) check("beat_value", k, got[k][i], e[i]);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    yumi = 1'b1;
    tick();
    yumi = 1'b0;

    // Mixed traffic, then a dump with yumi held high.
    events(3, 1'b1, 1'b0, 1'b0);
    events(2, 1'b0, 1'b1, 1'b0);
    events(1, 1'b1, 1'b0, 1'b1);
    cv = 1'b1; cy = 1'b0; ld = 1'b1; tick();
    cv = 1'b0; cy = 1'b1; tick();
    cy = 1'b0; ld = 1'b0;
    vcount = 0;
    dump(32'hAB, 99, 0, 1'b0);
    for (int k = 0; k < 3; k++) expect_beats(k, 32'hAB, acc_g, 32'd4, 32'd2, 32'd1, 32'd0);
    check("valid_cycles", 0, 32'(vcount), 32'd6);
    tick();

    // Load response coincident with acceptance.
    reset = 1'b1; tick(); reset = 1'b0;
    events(5, 1'b1, 1'b0, 1'b0);
    dump(32'h36, 99, 0, 1'b1);
    expect_beats(0, 32'h36, acc_g, 32'd5, 32'd0, 32'd0, 32'd0);
    expect_beats(1, 32'h36, acc_g, 32'd5, 32'd0, 32'd0, 32'd0);
    events(2, 1'b0, 1'b1, 1'b0);
    vcount = 0;
    dump(32'h37, 3, 4, 1'b0);
    expect_beats(0, 32'h37, acc_g, 32'd6, 32'd2, 32'd0, 32'd0);
    expect_beats(1, 32'h37, acc_g, 32'd1, 32'd2, 32'd0, 32'd0);
    expect_beats(2, 32'h37, acc_g, 32'd6, 32'd2, 32'd0, 32'd0);
    check("stall_valid_cycles", 0, 32'(vcount), 32'd10);

    // Narrow counters wrap.
    reset = 1'b1; tick(); reset = 1'b0;
    events(17, 1'b1, 1'b0, 1'b0);
    dump(32'h38, 99, 0, 1'b0);
    expect_beats(2, 32'h38, acc_g, 32'd1, 32'd0, 32'd0, 32'd0);
    expect_beats(0, 32'h38, acc_g, 32'd17, 32'd0, 32'd0, 32'd0);

    // Request held high across two dumps.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) got[k].delete();
    acc_cyc.delete();
    end_cyc.delete();
    pv = 1'b1; tag = 32'h39; yumi = 1'b1;
    for (int i = 0; i < 40 && !(acc_cyc.size() >= 2 && sbq[0].size() == 0); i++) begin
      if (acc_cyc.size() >= 2) pv = 1'b0;
      tick();
    end
    pv = 1'b0; yumi = 1'b0;
    check("b2b_beats", 0, 32'(got[0].size()), 32'd12);
    check("b2b_accepts", 0, 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() >= 2 && end_cyc.size() >= 1)
      check("b2b_gap", 0, 32'(acc_cyc[1]), 32'(end_cyc[0] + 1));
    else
      check("b2b_events", 0, 32'(end_cyc.size()), 32'd2);
    tick();

    // Reset in the middle of a dump.
    events(3, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) got[k].delete();
    pv = 1'b1; tag = 32'h40; tick();
    pv = 1'b0; yumi = 1'b1;
    for (int i = 0; i < 20 && got[0].size() < 2; i++) tick();
    yumi = 1'b0;
    check("pre_reset_beat", 0, dat[0], 32'd3);
    reset = 1'b1; tick(); reset = 1'b0;
    dump(32'h41, 99, 0, 1'b0);
    for (int k = 0; k < 3; k++) expect_beats(k, 32'h41, acc_g, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
